hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage RISC-V core (IF/ID/EX/MEM/WB) in RiscV_Filter.
- Keeps a shadow pipeline of destination-register info for EX, MEM and WB. From it, produces registered forwarding selects for the execute stage, a load-use bubble, branch flushes, and a whole-pipeline freeze while data memory is busy.
- Sits beside the ID/EX boundary and drives the execute stage's fw-select and flush inputs plus the stage enables.

Parameters:
- XLEN_IDX, 5, register index width
- CNT_W, 16, width of the stall/flush event counters

Ports:
- clk  in  1  pipeline clock
- rst  in  1  reset; synchronous, active-high
- i_id_rs1  in  5  rs1 index of instruction in ID
- i_id_rs2  in  5  rs2 index of instruction in ID
- i_id_use_rs1  in  1  ID instruction reads rs1
- i_id_use_rs2  in  1  ID instruction reads rs2
- i_id_rd  in  5  rd of instruction in ID
- i_id_wb_en  in  1  ID instruction writes rd
- i_id_wb_sel  in  2  ID writeback source: 0 ALU, 1 load, 2 pc4
- i_do_branch  in  1  taken branch/jump resolved in EX this cycle
- i_mem_busy  in  1  data memory cannot complete this cycle
- o_r1_fw_sel  out  2  registered rs1 forward select for EX: 0 reg, 1 MEM, 2 WB
- o_r2_fw_sel  out  2  registered rs2 forward select for EX
- o_pc_en  out  1  PC update enable
- o_ifid_en  out  1  IF/ID register enable
- o_ifid_flush  out  1  zero IF/ID on next edge
- o_idex_flush  out  1  insert bubble into ID/EX on next edge
- o_exmem_flush  out  1  flush input of execute stage (EX/MEM bubble)
- o_pipe_en  out  1  EX/MEM and MEM/WB enable (0 = freeze)
- o_stall_cnt  out  CNT_W  count of load-use stall cycles
- o_flush_cnt  out  CNT_W  count of branch flushes

Behaviour:
- Shadow regs: {rd, wb_en, wb_sel} for the EX, MEM and WB slots. On an advancing edge, ID→EX→MEM→WB. A bubble loads rd=0, wb_en=0, wb_sel=0.
- Effective writer: a slot counts as a writer only if wb_en=1 and rd≠0. x0 is never forwarded and never causes a stall.
- Forward select computation, done combinationally in ID and registered into o_rX_fw_sel when ID→EX advances:
  - EX-slot writer with rd==rsX and use_rsX → 1 (it will be in MEM).
  - Else MEM-slot writer with match → 2 (it will be in WB).
  - Else 0.
  - The nearer producer wins.
- WB-slot writers are not forwarded. The regfile must be write-through.
- MEM forward data is already wb_sel-muxed (ALU or pc4) outside this block.
- Load-use: the EX slot is a writer with wb_sel==1 and rd matches a used rsX of ID.
  - Response: o_pc_en=0, o_ifid_en=0, o_idex_flush=1 for exactly 1 cycle.
  - Fw selects become 0. The EX slot takes a bubble; MEM and WB advance.
  - On the next cycle the load is in MEM, so the re-evaluated select is 2.
  - o_stall_cnt increments.
- Branch: i_do_branch=1 with i_mem_busy=0.
  - Response: o_ifid_flush=1, o_idex_flush=1 for 1 cycle; o_pc_en=1 (fetch target).
  - The EX slot takes a bubble, fw selects become 0, and o_flush_cnt increments.
  - A branch suppresses any load-use stall in the same cycle. The branch's own EX/MEM result is kept, so o_exmem_flush=0.
- Mem busy: i_mem_busy=1 forces all enables to 0 (o_pc_en, o_ifid_en, o_pipe_en) and all flushes to 0.
  - Shadow regs, fw selects and counters hold.
  - A branch or load-use seen during busy is evaluated again in the first cycle after busy clears.
- Priority: mem_busy > branch > load-use > normal advance.
- Normal cycle: all enables 1, all flushes 0.
- Outputs are combinational from current state and inputs, except fw selects and counters, which are registered.
- Counters saturate at all-ones.
- Reset (sync, rst=1 at posedge):
  - Shadow regs and counters go to 0; fw selects go to 0.
  - o_idex_flush=1, o_ifid_flush=1 and o_exmem_flush=1 are asserted during rst so that downstream stages clear.
  - Other enables are 0 during rst.
  - Reset mid-stall discards the pending stall.

Decomposition:
- Shared package rv_pkg:
  - Constants WB_ALU=0, WB_LOAD=1, WB_PC4=2.
  - FW_REG=0, FW_MEM=1, FW_WB=2.
  - The shadow-slot struct {rd, wb_en, wb_sel}.
- One sub-module, fw_sel_calc: purely combinational, instantiated twice for rs1/rs2. Takes (rs, use, ex slot, mem slot) and returns sel.

Test Plan:
- Back-to-back ALU ops: add x5 then sub x6,x5,x1. Required: o_r1_fw_sel=1 in sub's EX cycle, o_r2_fw_sel=0, no stall.
- One-gap dependence: add x5; nop; or x7,x1,x5. Required: o_r2_fw_sel=2. Write to x0 followed by a use of x0 gives sel=0.
- Load-use: lw x8 then add x9,x8,x8. Required: exactly 1 cycle of pc_en=0, ifid_en=0, idex_flush=1; then both sels=2; o_stall_cnt=1.
- Taken branch coinciding with a load-use condition in ID. Required: ifid_flush=idex_flush=1 for 1 cycle, no stall, o_flush_cnt=1, o_stall_cnt unchanged.
- i_mem_busy held 3 cycles with a branch in EX. Required: all enables 0 for 3 cycles with state held; flush fires on the 4th cycle.
- rst asserted for 1 cycle during a load-use stall. Required: next cycle has counters=0 and sels=0, no residual stall, and normal advance after rst drops.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared types and constants for the RISC-V pipeline sequencing logic.
package rv_pkg;

   localparam int REG_IDX_W = 5;

   // Writeback source encodings
   localparam logic [1:0] WB_ALU  = 2'd0;
   localparam logic [1:0] WB_LOAD = 2'd1;
   localparam logic [1:0] WB_PC4  = 2'd2;

   // Execute-stage operand forward selects
   localparam logic [1:0] FW_REG = 2'd0;
   localparam logic [1:0] FW_MEM = 2'd1;
   localparam logic [1:0] FW_WB  = 2'd2;

   // Destination info carried by an instruction through the shadow pipeline
   typedef struct packed {
      logic [REG_IDX_W-1:0] rd;
      logic                 wb_en;
      logic [1:0]           wb_sel;
   } slot_t;

   // Producer view of a slot: only the destination and whether it really writes
   typedef struct packed {
      logic [REG_IDX_W-1:0] rd;
      logic                 wr;
   } fwd_src_t;

   localparam slot_t BUBBLE = '{rd: '0, wb_en: 1'b0, wb_sel: WB_ALU};

   // A slot is an effective writer only when it writes a register other than x0
   function automatic fwd_src_t to_src(input slot_t s);
      fwd_src_t r;
      r.rd = s.rd;
      r.wr = s.wb_en && (s.rd != '0);
      return r;
   endfunction

endpackage

// File: rtl/fw_sel_calc.sv
// Forward select for one source operand of the instruction in ID.
// The nearer producer (EX slot) wins over the older one (MEM slot).
module fw_sel_calc
   import rv_pkg::*;
(
   input  logic [REG_IDX_W-1:0] i_rs,
   input  logic                 i_use,
   input  fwd_src_t             i_ex,
   input  fwd_src_t             i_mem,
   output logic [1:0]           o_sel
);

   // EX-slot producer will sit in MEM next cycle, MEM-slot producer in WB
   always_comb begin
      o_sel = FW_REG;
      if (i_use && (i_rs != '0)) begin
         if (i_ex.wr && (i_ex.rd == i_rs)) begin
            o_sel = FW_MEM;
         end else if (i_mem.wr && (i_mem.rd == i_rs)) begin
            o_sel = FW_WB;
         end
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage core: forwarding selects,
// load-use bubbles, branch flushes and whole-pipeline freeze on memory busy.
// WB-stage writers are covered by the write-through regfile and never affect
// any output, so only the EX and MEM slots of the shadow pipeline are stored.
module hazard_ctrl
   import rv_pkg::*;
#(
   parameter int XLEN_IDX = 5,
   parameter int CNT_W    = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [XLEN_IDX-1:0] i_id_rs1,
   input  logic [XLEN_IDX-1:0] i_id_rs2,
   input  logic                i_id_use_rs1,
   input  logic                i_id_use_rs2,
   input  logic [XLEN_IDX-1:0] i_id_rd,
   input  logic                i_id_wb_en,
   input  logic [1:0]          i_id_wb_sel,
   input  logic                i_do_branch,
   input  logic                i_mem_busy,
   output logic [1:0]          o_r1_fw_sel,
   output logic [1:0]          o_r2_fw_sel,
   output logic                o_pc_en,
   output logic                o_ifid_en,
   output logic                o_ifid_flush,
   output logic                o_idex_flush,
   output logic                o_exmem_flush,
   output logic                o_pipe_en,
   output logic [CNT_W-1:0]    o_stall_cnt,
   output logic [CNT_W-1:0]    o_flush_cnt
);

   slot_t                ex_q, ex_d;
   fwd_src_t             mem_q, mem_d;
   logic [1:0]           r1_fw_sel_q, r1_fw_sel_d;
   logic [1:0]           r2_fw_sel_q, r2_fw_sel_d;
   logic [CNT_W-1:0]     stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0]     flush_cnt_q, flush_cnt_d;

   logic [REG_IDX_W-1:0] id_rs1;
   logic [REG_IDX_W-1:0] id_rs2;
   slot_t                id_slot;
   fwd_src_t             ex_src;
   logic [1:0]           r1_calc_sel;
   logic [1:0]           r2_calc_sel;
   logic                 load_use;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   assign id_rs1  = REG_IDX_W'(i_id_rs1);
   assign id_rs2  = REG_IDX_W'(i_id_rs2);
   assign id_slot = '{rd: REG_IDX_W'(i_id_rd), wb_en: i_id_wb_en, wb_sel: i_id_wb_sel};
   assign ex_src  = to_src(ex_q);

   fw_sel_calc u_r1_calc (
      .i_rs  (id_rs1),
      .i_use (i_id_use_rs1),
      .i_ex  (ex_src),
      .i_mem (mem_q),
      .o_sel (r1_calc_sel)
   );

   fw_sel_calc u_r2_calc (
      .i_rs  (id_rs2),
      .i_use (i_id_use_rs2),
      .i_ex  (ex_src),
      .i_mem (mem_q),
      .o_sel (r2_calc_sel)
   );

   // A load in EX cannot forward yet, so a dependent instruction in ID must wait
   always_comb begin
      load_use = ex_src.wr && (ex_q.wb_sel == WB_LOAD) &&
                 ((i_id_use_rs1 && (ex_q.rd == id_rs1)) ||
                  (i_id_use_rs2 && (ex_q.rd == id_rs2)));
   end

   // Stage enables/flushes and next shadow state; priority busy > branch > load-use
   always_comb begin
      ex_d          = ex_q;
      mem_d         = mem_q;
      r1_fw_sel_d   = r1_fw_sel_q;
      r2_fw_sel_d   = r2_fw_sel_q;
      stall_cnt_d   = stall_cnt_q;
      flush_cnt_d   = flush_cnt_q;
      o_pc_en       = 1'b0;
      o_ifid_en     = 1'b0;
      o_ifid_flush  = 1'b0;
      o_idex_flush  = 1'b0;
      o_exmem_flush = 1'b0;
      o_pipe_en     = 1'b0;
      if (rst) begin
         // Clear every downstream stage while reset is held
         o_ifid_flush  = 1'b1;
         o_idex_flush  = 1'b1;
         o_exmem_flush = 1'b1;
      end else if (i_mem_busy) begin
         // Whole pipeline frozen: enables low, state held
      end else if (i_do_branch) begin
         // Fetch the target, squash IF/ID and ID/EX; the branch itself moves on
         o_pc_en      = 1'b1;
         o_ifid_en    = 1'b1;
         o_ifid_flush = 1'b1;
         o_idex_flush = 1'b1;
         o_pipe_en    = 1'b1;
         ex_d         = BUBBLE;
         mem_d        = ex_src;
         r1_fw_sel_d  = FW_REG;
         r2_fw_sel_d  = FW_REG;
         flush_cnt_d  = sat_inc(flush_cnt_q);
      end else if (load_use) begin
         // Hold PC and IF/ID, bubble into EX while the load moves to MEM
         o_idex_flush = 1'b1;
         o_pipe_en    = 1'b1;
         ex_d         = BUBBLE;
         mem_d        = ex_src;
         r1_fw_sel_d  = FW_REG;
         r2_fw_sel_d  = FW_REG;
         stall_cnt_d  = sat_inc(stall_cnt_q);
      end else begin
         o_pc_en      = 1'b1;
         o_ifid_en    = 1'b1;
         o_pipe_en    = 1'b1;
         ex_d         = id_slot;
         mem_d        = ex_src;
         r1_fw_sel_d  = r1_calc_sel;
         r2_fw_sel_d  = r2_calc_sel;
      end
   end

   // Shadow slots, forward selects and counters with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         ex_q        <= BUBBLE;
         mem_q       <= '0;
         r1_fw_sel_q <= FW_REG;
         r2_fw_sel_q <= FW_REG;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         ex_q        <= ex_d;
         mem_q       <= mem_d;
         r1_fw_sel_q <= r1_fw_sel_d;
         r2_fw_sel_q <= r2_fw_sel_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign o_r1_fw_sel = r1_fw_sel_q;
   assign o_r2_fw_sel = r2_fw_sel_q;
   assign o_stall_cnt = stall_cnt_q;
   assign o_flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Testbench for hazard_ctrl: directed scenarios plus randomized traffic checked
// against an in-flight instruction queue model.
module tb_hazard_ctrl;

   localparam int CNT_W = 3;
   localparam int CMAX  = (1 << CNT_W) - 1;

   // {pc_en, ifid_en, ifid_flush, idex_flush, exmem_flush, pipe_en}
   localparam logic [5:0] C_RST  = 6'b001110;
   localparam logic [5:0] C_HOLD = 6'b000000;
   localparam logic [5:0] C_BR   = 6'b111101;
   localparam logic [5:0] C_LU   = 6'b000101;
   localparam logic [5:0] C_ADV  = 6'b110001;

   logic             clk = 1'b0;
   logic             rst;
   logic [4:0]       i_id_rs1, i_id_rs2, i_id_rd;
   logic             i_id_use_rs1, i_id_use_rs2, i_id_wb_en;
   logic [1:0]       i_id_wb_sel;
   logic             i_do_branch, i_mem_busy;
   logic [1:0]       o_r1_fw_sel, o_r2_fw_sel;
   logic             o_pc_en, o_ifid_en, o_ifid_flush, o_idex_flush, o_exmem_flush, o_pipe_en;
   logic [CNT_W-1:0] o_stall_cnt, o_flush_cnt;
   logic [5:0]       ctrl;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   hazard_ctrl #(.XLEN_IDX(5), .CNT_W(CNT_W)) dut (
      .clk           (clk),
      .rst           (rst),
      .i_id_rs1      (i_id_rs1),
      .i_id_rs2      (i_id_rs2),
      .i_id_use_rs1  (i_id_use_rs1),
      .i_id_use_rs2  (i_id_use_rs2),
      .i_id_rd       (i_id_rd),
      .i_id_wb_en    (i_id_wb_en),
      .i_id_wb_sel   (i_id_wb_sel),
      .i_do_branch   (i_do_branch),
      .i_mem_busy    (i_mem_busy),
      .o_r1_fw_sel   (o_r1_fw_sel),
      .o_r2_fw_sel   (o_r2_fw_sel),
      .o_pc_en       (o_pc_en),
      .o_ifid_en     (o_ifid_en),
      .o_ifid_flush  (o_ifid_flush),
      .o_idex_flush  (o_idex_flush),
      .o_exmem_flush (o_exmem_flush),
      .o_pipe_en     (o_pipe_en),
      .o_stall_cnt   (o_stall_cnt),
      .o_flush_cnt   (o_flush_cnt)
   );

   assign ctrl = {o_pc_en, o_ifid_en, o_ifid_flush, o_idex_flush, o_exmem_flush, o_pipe_en};

   // Reference model: instructions past ID, newest (in EX) at the back
   typedef struct {
      int rd;
      bit wr;
      bit ld;
   } instr_t;

   instr_t flight[$];
   int     m_sel1, m_sel2, m_stall, m_flush;

   function automatic int producer_dist(int rs, bit use_it);
      instr_t p;
      if (!use_it || rs == 0) return 0;
      for (int d = 1; d <= 2; d++) begin
         p = flight[flight.size() - d];
         if (p.wr && p.rd == rs) return d;
      end
      return 0;
   endfunction

   function automatic bit m_load_use();
      instr_t p;
      p = flight[flight.size() - 1];
      return p.ld && p.wr &&
             ((i_id_use_rs1 && int'(i_id_rs1) == p.rd) || (i_id_use_rs2 && int'(i_id_rs2) == p.rd));
   endfunction

   function automatic logic [5:0] m_ctrl();
      if (rst) return C_RST;
      if (i_mem_busy) return C_HOLD;
      if (i_do_branch) return C_BR;
      if (m_load_use()) return C_LU;
      return C_ADV;
   endfunction

   task automatic model_reset();
      instr_t bub;
      bub = '{rd: 0, wr: 1'b0, ld: 1'b0};
      flight.delete();
      repeat (3) flight.push_back(bub);
      m_sel1 = 0; m_sel2 = 0; m_stall = 0; m_flush = 0;
   endtask

   // One clock: advance DUT and model from inputs held since the last negedge
   task automatic cycle();
      instr_t bub, idi;
      int     n1, n2;
      bit     lu;
      bub    = '{rd: 0, wr: 1'b0, ld: 1'b0};
      idi.rd = int'(i_id_rd);
      idi.wr = i_id_wb_en && (i_id_rd != 5'd0);
      idi.ld = (i_id_wb_sel == 2'd1);
      lu     = m_load_use();
      n1     = producer_dist(int'(i_id_rs1), i_id_use_rs1);
      n2     = producer_dist(int'(i_id_rs2), i_id_use_rs2);
      @(posedge clk);
      if (rst) begin
         model_reset();
      end else if (i_mem_busy) begin
      end else if (i_do_branch) begin
         void'(flight.pop_front());
         flight.push_back(bub);
         m_sel1 = 0; m_sel2 = 0;
         if (m_flush < CMAX) m_flush++;
      end else if (lu) begin
         void'(flight.pop_front());
         flight.push_back(bub);
         m_sel1 = 0; m_sel2 = 0;
         if (m_stall < CMAX) m_stall++;
      end else begin
         void'(flight.pop_front());
         flight.push_back(idi);
         m_sel1 = n1; m_sel2 = n2;
      end
      @(negedge clk);
   endtask

   task automatic set_id(input int rs1, input bit u1, input int rs2, input bit u2,
                         input int rd, input bit we, input int sel);
      i_id_rs1 = 5'(rs1); i_id_use_rs1 = u1;
      i_id_rs2 = 5'(rs2); i_id_use_rs2 = u2;
      i_id_rd  = 5'(rd);  i_id_wb_en   = we;
      i_id_wb_sel = 2'(sel);
   endtask

   task automatic nop_id();
      set_id(0, 1'b0, 0, 1'b0, 0, 1'b0, 0);
   endtask

   task automatic test_reset();
      model_reset();
      rst = 1'b1; i_do_branch = 1'b0; i_mem_busy = 1'b0;
      set_id(3, 1'b1, 3, 1'b1, 4, 1'b1, 1);
      @(negedge clk); #1;
      checks++;
      if (ctrl !== C_RST) begin errors++; $display("FAIL reset_ctrl: got %b expected %b", ctrl, C_RST); end
      checks++;
      if (o_r1_fw_sel !== 2'd0 || o_r2_fw_sel !== 2'd0) begin
         errors++; $display("FAIL reset_sel: got %0d/%0d expected 0/0", o_r1_fw_sel, o_r2_fw_sel);
      end
      checks++;
      if (o_stall_cnt !== '0 || o_flush_cnt !== '0) begin
         errors++; $display("FAIL reset_cnt: got %0d/%0d expected 0/0", o_stall_cnt, o_flush_cnt);
      end
      cycle();
      nop_id(); rst = 1'b0; #1;
      checks++;
      if (ctrl !== C_ADV) begin errors++; $display("FAIL reset_release: got %b expected %b", ctrl, C_ADV); end
      cycle(); cycle();
   endtask

   task automatic test_back_to_back();
      set_id(1, 1'b1, 2, 1'b1, 5, 1'b1, 0); #1;   // add x5,x1,x2
      cycle();
      set_id(5, 1'b1, 1, 1'b1, 6, 1'b1, 0); #1;   // sub x6,x5,x1
      checks++;
      if (ctrl !== C_ADV) begin errors++; $display("FAIL b2b_nostall: got %b expected %b", ctrl, C_ADV); end
      cycle();
      nop_id(); #1;
      checks++;
      if (o_r1_fw_sel !== 2'd1) begin errors++; $display("FAIL b2b_r1: got %0d expected 1", o_r1_fw_sel); end
      checks++;
      if (o_r2_fw_sel !== 2'd0) begin errors++; $display("FAIL b2b_r2: got %0d expected 0", o_r2_fw_sel); end
      cycle(); cycle(); cycle();
   endtask

   task automatic test_one_gap();
      set_id(1, 1'b1, 2, 1'b1, 5, 1'b1, 0); cycle();   // add x5
      nop_id(); cycle();
      set_id(1, 1'b1, 5, 1'b1, 7, 1'b1, 0); cycle();   // or x7,x1,x5
      nop_id(); #1;
      checks++;
      if (o_r2_fw_sel !== 2'd2) begin errors++; $display("FAIL gap_r2: got %0d expected 2", o_r2_fw_sel); end
      checks++;
      if (o_r1_fw_sel !== 2'd0) begin errors++; $display("FAIL gap_r1: got %0d expected 0", o_r1_fw_sel); end
      cycle(); cycle();
      set_id(1, 1'b1, 2, 1'b1, 0, 1'b1, 0); cycle();   // add x0
      set_id(0, 1'b1, 0, 1'b1, 3, 1'b1, 0); cycle();   // add x3,x0,x0
      nop_id(); #1;
      checks++;
      if (o_r1_fw_sel !== 2'd0 || o_r2_fw_sel !== 2'd0) begin
         errors++; $display("FAIL x0_fw: got %0d/%0d expected 0/0", o_r1_fw_sel, o_r2_fw_sel);
      end
      set_id(1, 1'b1, 0, 1'b0, 0, 1'b1, 1); cycle();   // lw x0
      set_id(0, 1'b1, 0, 1'b1, 4, 1'b1, 0); #1;        // add x4,x0,x0
      checks++;
      if (ctrl !== C_ADV) begin errors++; $display("FAIL x0_nostall: got %b expected %b", ctrl, C_ADV); end
      cycle(); nop_id(); cycle(); cycle();
   endtask

   task automatic test_load_use();
      set_id(2, 1'b1, 0, 1'b0, 8, 1'b1, 1); cycle();   // lw x8
      set_id(8, 1'b1, 8, 1'b1, 9, 1'b1, 0); #1;        // add x9,x8,x8
      checks++;
      if (ctrl !== C_LU) begin errors++; $display("FAIL lu_stall: got %b expected %b", ctrl, C_LU); end
      cycle(); #1;
      checks++;
      if (ctrl !== C_ADV) begin errors++; $display("FAIL lu_one_cycle: got %b expected %b", ctrl, C_ADV); end
      checks++;
      if (o_stall_cnt !== 3'd1) begin errors++; $display("FAIL lu_cnt: got %0d expected 1", o_stall_cnt); end
      checks++;
      if (o_r1_fw_sel !== 2'd0 || o_r2_fw_sel !== 2'd0) begin
         errors++; $display("FAIL lu_bubble_sel: got %0d/%0d expected 0/0", o_r1_fw_sel, o_r2_fw_sel);
      end
      cycle(); nop_id(); #1;
      checks++;
      if (o_r1_fw_sel !== 2'd2 || o_r2_fw_sel !== 2'd2) begin
         errors++; $display("FAIL lu_sel_wb: got %0d/%0d expected 2/2", o_r1_fw_sel, o_r2_fw_sel);
      end
      cycle(); cycle(); cycle();
   endtask

   task automatic test_branch_load_use();
      set_id(3, 1'b1, 0, 1'b0, 10, 1'b1, 1); cycle();  // lw x10
      set_id(10, 1'b1, 0, 1'b0, 11, 1'b1, 0);          // dependent add in ID
      i_do_branch = 1'b1; #1;
      checks++;
      if (ctrl !== C_BR) begin errors++; $display("FAIL br_ctrl: got %b expected %b", ctrl, C_BR); end
      cycle();
      i_do_branch = 1'b0; nop_id(); #1;
      checks++;
      if (o_flush_cnt !== 3'd1) begin errors++; $display("FAIL br_flush_cnt: got %0d expected 1", o_flush_cnt); end
      checks++;
      if (o_stall_cnt !== 3'd1) begin errors++; $display("FAIL br_stall_cnt: got %0d expected 1", o_stall_cnt); end
      checks++;
      if (ctrl !== C_ADV) begin errors++; $display("FAIL br_after: got %b expected %b", ctrl, C_ADV); end
      cycle(); cycle(); cycle();
   endtask

   task automatic test_mem_busy();
      set_id(0, 1'b0, 0, 1'b0, 11, 1'b1, 0); cycle();   // add x11
      set_id(11, 1'b1, 0, 1'b0, 13, 1'b1, 0); cycle();  // add x13,x11
      set_id(13, 1'b1, 11, 1'b1, 14, 1'b1, 0);
      i_mem_busy = 1'b1; i_do_branch = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++;
         if (ctrl !== C_HOLD) begin errors++; $display("FAIL busy_ctrl[%0d]: got %b expected %b", i, ctrl, C_HOLD); end
         checks++;
         if (o_r1_fw_sel !== 2'd1 || o_flush_cnt !== 3'd1) begin
            errors++; $display("FAIL busy_hold[%0d]: got sel %0d cnt %0d expected sel 1 cnt 1", i, o_r1_fw_sel, o_flush_cnt);
         end
         cycle();
      end
      i_mem_busy = 1'b0; #1;
      checks++;
      if (ctrl !== C_BR) begin errors++; $display("FAIL busy_then_br: got %b expected %b", ctrl, C_BR); end
      cycle();
      i_do_branch = 1'b0;
      set_id(13, 1'b1, 11, 1'b1, 15, 1'b1, 0); #1;
      checks++;
      if (o_flush_cnt !== 3'd2 || o_r1_fw_sel !== 2'd0 || o_r2_fw_sel !== 2'd0) begin
         errors++; $display("FAIL busy_br_state: got cnt %0d sel %0d/%0d expected 2 0/0", o_flush_cnt, o_r1_fw_sel, o_r2_fw_sel);
      end
      cycle(); nop_id(); #1;
      checks++;
      if (o_r1_fw_sel !== 2'd2 || o_r2_fw_sel !== 2'd0) begin
         errors++; $display("FAIL busy_shadow_held: got %0d/%0d expected 2/0", o_r1_fw_sel, o_r2_fw_sel);
      end
      cycle(); cycle();
   endtask

   task automatic test_saturation();
      i_do_branch = 1'b1;
      repeat (9) cycle();
      i_do_branch = 1'b0; #1;
      checks++;
      if (o_flush_cnt !== 3'd7) begin errors++; $display("FAIL flush_sat: got %0d expected 7", o_flush_cnt); end
      cycle();
   endtask

   task automatic test_reset_mid_stall();
      set_id(4, 1'b1, 0, 1'b0, 15, 1'b1, 1); cycle();   // lw x15
      set_id(15, 1'b1, 0, 1'b0, 16, 1'b1, 0); #1;
      checks++;
      if (ctrl !== C_LU) begin errors++; $display("FAIL rst_pre_stall: got %b expected %b", ctrl, C_LU); end
      rst = 1'b1; #1;
      checks++;
      if (ctrl !== C_RST) begin errors++; $display("FAIL rst_mid_ctrl: got %b expected %b", ctrl, C_RST); end
      cycle();
      rst = 1'b0; #1;
      checks++;
      if (o_stall_cnt !== '0 || o_flush_cnt !== '0 || o_r1_fw_sel !== 2'd0 || o_r2_fw_sel !== 2'd0) begin
         errors++; $display("FAIL rst_mid_state: got cnt %0d/%0d sel %0d/%0d expected all 0", o_stall_cnt, o_flush_cnt, o_r1_fw_sel, o_r2_fw_sel);
      end
      checks++;
      if (ctrl !== C_ADV) begin errors++; $display("FAIL rst_mid_no_stall: got %b expected %b", ctrl, C_ADV); end
      cycle(); nop_id(); #1;
      checks++;
      if (o_r1_fw_sel !== 2'd0) begin errors++; $display("FAIL rst_mid_discard: got %0d expected 0", o_r1_fw_sel); end
      cycle();
   endtask

   task automatic test_random();
      rst = 1'b1; i_do_branch = 1'b0; i_mem_busy = 1'b0; nop_id();
      cycle();
      rst = 1'b0;
      for (int n = 0; n < 600; n++) begin
         set_id(int'($urandom_range(0, 3)), 1'($urandom), int'($urandom_range(0, 3)), 1'($urandom),
                int'($urandom_range(0, 3)), 1'($urandom), int'($urandom_range(0, 2)));
         i_do_branch = ($urandom_range(0, 5) == 0);
         i_mem_busy  = ($urandom_range(0, 4) == 0);
         rst         = ($urandom_range(0, 149) == 0);
         #1;
         checks++;
         if (ctrl !== m_ctrl()) begin errors++; $display("FAIL rnd_ctrl[%0d]: got %b expected %b", n, ctrl, m_ctrl()); end
         checks++;
         if (o_r1_fw_sel !== 2'(m_sel1) || o_r2_fw_sel !== 2'(m_sel2)) begin
            errors++; $display("FAIL rnd_sel[%0d]: got %0d/%0d expected %0d/%0d", n, o_r1_fw_sel, o_r2_fw_sel, m_sel1, m_sel2);
         end
         checks++;
         if (o_stall_cnt !== CNT_W'(m_stall) || o_flush_cnt !== CNT_W'(m_flush)) begin
            errors++; $display("FAIL rnd_cnt[%0d]: got %0d/%0d expected %0d/%0d", n, o_stall_cnt, o_flush_cnt, m_stall, m_flush);
         end
         cycle();
      end
      rst = 1'b0; i_do_branch = 1'b0; i_mem_busy = 1'b0;
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_one_gap();
      test_load_use();
      test_branch_load_use();
      test_mem_busy();
      test_saturation();
      test_reset_mid_stall();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
